shift_seq: RTL and testbench
============================

# shift_seq

Command sequencer for the 8-bit multi-mode shift register. It accepts one command at a time over a valid/ready handshake and drives the register's `select`, `in_date` and `decide` lines for the required number of cycles. It then returns the register's final value over a valid/ready response channel. It sits between a host or test driver and the shift register, and it holds that register steady whenever no command is running.

## Interface
- `WIDTH`, default 8: datapath width.
- `CNT_W`, default 3: width of the shift-count field. The run length is `cmd_cnt + 1`, so 1..8 cycles.
- `clk` in 1: the only clock.
- `clr` in 1: reset, synchronous and active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: controller can accept a command.
- `cmd_op` in 3: operation, using the register's select encoding.
  - 0 clear, 1 load, 2 logical right, 3 logical left, 4 arithmetic right.
  - 5 serial-in, 6 rotate right, 7 rotate left.
- `cmd_data` in WIDTH: load value for op 1, or the serial bit stream for op 5.
- `cmd_cnt` in CNT_W: number of shift cycles minus 1. Ignored for ops 0 and 1.
- `sel` out 3: drives the register's `select`.
- `reg_din` out WIDTH: drives the register's `in_date`.
- `reg_decide` out 1: drives the register's `decide`.
- `reg_q` in WIDTH: the register's `out_date`, fed back.
- `rsp_valid` out 1: result available.
- `rsp_data` out WIDTH: result value.
- `rsp_ready` in 1: consumer accepts the result.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **States:** IDLE, RUN, RESP. All state and captured fields are registered.
- **IDLE:**
  - `cmd_ready` = 1.
  - Hold drive: `sel` = 1 and `reg_din` = `reg_q`. The register reloads its own value, because it has no native hold code.
- **Command accept:** on `cmd_valid & cmd_ready`, capture `op`, `data` and run length N.
  - N = 1 for ops 0 and 1; otherwise N = `cmd_cnt` + 1.
  - Clear the step index k to 0 and go to RUN.
- **RUN:**
  - Drive `sel` = captured op.
  - `reg_din` = captured data for op 1; otherwise `reg_din` = `reg_q`.
  - `reg_decide` = captured `data[k]` for op 5; 0 for every other op.
  - Increment k each cycle. After N cycles go to RESP.
- **RESP:**
  - Hold drive as in IDLE.
  - `rsp_valid` = 1 and `rsp_data` = `reg_q`, which is stable because the register is in hold.
  - On `rsp_valid & rsp_ready` go to IDLE.
- **Ready outside IDLE:** `cmd_ready` = 0 in RUN and RESP. `cmd_*` inputs are ignored there and may change freely after accept.
- **`rsp_ready` outside RESP:** has no effect.
- **Default for unused outputs:** `reg_decide` = 0 outside RUN.
- **Reset (`clr` = 1), including mid-RUN or mid-RESP:**
  - During the reset cycle: `sel` = 0, so the register clears on the same edge.
  - During the reset cycle: `cmd_ready`, `rsp_valid`, `busy` and `reg_decide` are all 0, and `rsp_data` = 0.
  - After reset: state IDLE, k = 0, and the captured fields are 0.
  - Any in-flight command is discarded with no response.

## Timing
- **Latency:**
  - Cycle 0: command accepted.
  - Cycles 1..N: RUN, `sel` = op. The register updates at the end of each of these cycles.
  - Cycle N+1: `rsp_valid` = 1, with `rsp_data` holding the value after N operations.
  - Accept to response is N+1 cycles: 2 for ops 0/1, and up to 9 for an 8-step shift.
- **Response hold:** `rsp_valid` stays high, with `rsp_data` stable, until `rsp_ready` is sampled high.
- **Turnaround:**
  - After the response handshake, the controller returns to IDLE; `cmd_ready` = 1 in the following cycle.
  - Minimum command-to-command spacing is N+2 cycles when `rsp_ready` is held high.
- **Reset values of outputs (first cycle after `clr` deasserts):**
  - `cmd_ready` = 1, `busy` = 0, `rsp_valid` = 0.
  - `sel` = 1 (hold), `reg_din` = `reg_q`, `reg_decide` = 0.
- **Simultaneous events:**
  - `clr` overrides every handshake in the same cycle.
  - A `cmd_valid` asserted during RESP is held off until IDLE, then accepted in the first IDLE cycle.

## Test plan
- **Reset then load:** `clr` for 2 cycles, then load `cmd_op` = 1, `cmd_data` = 0xA5 → `sel` = 1 with `reg_din` = 0xA5 for 1 cycle. `rsp_valid` rises 2 cycles after accept with `rsp_data` = 0xA5.
- **Rotate right:** after loading 0xA5, send op 6 with `cmd_cnt` = 3 → `sel` = 6 for exactly 4 cycles, then `rsp_data` = 0x5A. `busy` is high for 5 cycles.
- **Arithmetic right:** load 0x80, then op 4 with `cmd_cnt` = 2 → `rsp_data` = 0xF0.
- **Serial-in:** op 5 with `cmd_data` = 0b1011_0010 and `cmd_cnt` = 7 → `reg_decide` sequence over RUN cycles 1..8 is 0,1,0,0,1,1,0,1. `reg_decide` = 0 otherwise.
- **Backpressure and hold:**
  - Hold `rsp_ready` = 0 for 5 cycles → `rsp_valid` and `rsp_data` stay stable, `sel` = 1, `reg_din` = `reg_q`, and the register value is unchanged.
  - A command offered during this time gets no `cmd_ready` until the cycle after the response handshake.
- **Reset mid-operation:** assert `clr` during cycle 2 of an 8-step rotate → `sel` = 0 in that cycle and the register reads 0 afterwards. No `rsp_valid` ever appears, and the controller returns to IDLE with `cmd_ready` = 1.

Source files
------------

// File: rtl/shift_seq.sv
// Command sequencer for the 8-bit multi-mode shift register: accepts one command,
// drives select/in_date/decide for the run length, then returns the register value.
module shift_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic [2:0]       sel,
  output logic [WIDTH-1:0] reg_din,
  output logic             reg_decide,
  input  logic [WIDTH-1:0] reg_q,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ready,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_e;
  typedef enum logic [2:0] {
    OP_CLR, OP_LOAD, OP_SHR, OP_SHL, OP_ASR, OP_SER, OP_ROR, OP_ROL
  } op_e;

  state_e           state, state_next;
  op_e              op, cmd_op_e, sel_op;
  logic [WIDTH-1:0] data;
  logic [CNT_W-1:0] last, k;
  logic             accept;

  assign cmd_op_e = op_e'(cmd_op);
  assign accept   = (state == IDLE) && cmd_valid;
  assign sel      = sel_op;

  // 'last' holds N-1 so the step index never needs an extra bit.
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      op    <= OP_CLR;
      data  <= '0;
      last  <= '0;
      k     <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op   <= cmd_op_e;
        data <= cmd_data;
        last <= (cmd_op_e == OP_CLR || cmd_op_e == OP_LOAD) ? '0 : cmd_cnt;
        k    <= '0;
      end else if (state == RUN) begin
        k <= k + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data   = '0;
    sel_op     = OP_LOAD;
    reg_din    = reg_q;
    reg_decide = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = RUN;
      end
      RUN: begin
        sel_op = op;
        if (op == OP_LOAD) reg_din = data;
        if (op == OP_SER)  reg_decide = data[k];
        if (k == last)     state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = reg_q;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Reset drives a clear into the register on the same edge.
    if (clr) begin
      state_next = IDLE;
      sel_op     = OP_CLR;
      cmd_ready  = 1'b0;
      rsp_valid  = 1'b0;
      rsp_data   = '0;
      reg_decide = 1'b0;
      busy       = 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq with a behavioural model of the attached shift register.
module tb_shift_seq;

  logic       clk = 1'b0;
  logic       clr;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic [2:0] cmd_cnt;
  logic [2:0] sel;
  logic [7:0] reg_din;
  logic       reg_decide;
  logic [7:0] reg_q;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_ready;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  shift_seq #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .clr(clr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt),
    .sel(sel), .reg_din(reg_din), .reg_decide(reg_decide), .reg_q(reg_q),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Shift register model; serial-in shifts decide into the MSB.
  always @(posedge clk) begin
    case (sel)
      3'd0: reg_q <= 8'h00;
      3'd1: reg_q <= reg_din;
      3'd2: reg_q <= {1'b0, reg_q[7:1]};
      3'd3: reg_q <= {reg_q[6:0], 1'b0};
      3'd4: reg_q <= {reg_q[7], reg_q[7:1]};
      3'd5: reg_q <= {reg_decide, reg_q[7:1]};
      3'd6: reg_q <= {reg_q[0], reg_q[7:1]};
      default: reg_q <= {reg_q[6:0], reg_q[7]};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a command from IDLE with rsp_ready high, check every RUN cycle and the response.
  task automatic do_cmd(input logic [2:0] op, input logic [7:0] data, input logic [2:0] cnt,
                        input logic [7:0] exp_rsp, input int exp_run, input logic [7:0] exp_dec);
    int run = 0;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_cnt = cnt; rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'h00; cmd_cnt = 3'd0;
    while (!rsp_valid && run < 20) begin
      chk("run_sel", sel, op);
      chk("run_busy", busy, 1);
      chk("run_ready", cmd_ready, 0);
      chk("run_decide", reg_decide, (op == 3'd5) ? exp_dec[run] : 1'b0);
      run++;
      tick();
    end
    chk("run_len", run, exp_run);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_data", rsp_data, exp_rsp);
    chk("rsp_sel_hold", sel, 1);
    chk("rsp_busy", busy, 1);
    chk("rsp_decide", reg_decide, 0);
    tick();
    chk("turn_ready", cmd_ready, 1);
    chk("turn_busy", busy, 0);
    chk("turn_rsp_valid", rsp_valid, 0);
  endtask

  initial begin
    int seen;
    clr = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 8'h00; cmd_cnt = 3'd0;
    rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_sel", sel, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_decide", reg_decide, 0);
    clr = 1'b0;
    #1;
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_sel", sel, 1);
    chk("post_rst_din", reg_din, 8'h00);

    // load, rotate, arithmetic right, serial-in, clear and left variants
    do_cmd(3'd1, 8'hA5, 3'd5, 8'hA5, 1, 8'h00);
    chk("idle_din_hold", reg_din, 8'hA5);
    do_cmd(3'd6, 8'h00, 3'd3, 8'h5A, 4, 8'h00);
    do_cmd(3'd1, 8'h80, 3'd0, 8'h80, 1, 8'h00);
    do_cmd(3'd4, 8'h00, 3'd2, 8'hF0, 3, 8'h00);
    do_cmd(3'd5, 8'hB2, 3'd7, 8'hB2, 8, 8'hB2);
    do_cmd(3'd0, 8'hFF, 3'd7, 8'h00, 1, 8'h00);
    do_cmd(3'd1, 8'h81, 3'd0, 8'h81, 1, 8'h00);
    do_cmd(3'd7, 8'h00, 3'd0, 8'h03, 1, 8'h00);
    do_cmd(3'd3, 8'h00, 3'd1, 8'h0C, 2, 8'h00);
    do_cmd(3'd2, 8'h00, 3'd2, 8'h01, 3, 8'h00);

    // backpressure: response held, competing command stalled
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_data = 8'h3C; cmd_cnt = 3'd0; rsp_ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    cmd_valid = 1'b1; cmd_op = 3'd6; cmd_data = 8'h00; cmd_cnt = 3'd0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_data", rsp_data, 8'h3C);
      chk("bp_sel", sel, 1);
      chk("bp_din", reg_din, 8'h3C);
      chk("bp_ready", cmd_ready, 0);
      tick();
      chk("bp_reg", reg_q, 8'h3C);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_turn_ready", cmd_ready, 1);
    chk("bp_turn_valid", rsp_valid, 0);
    tick();
    cmd_valid = 1'b0;
    chk("bp_next_sel", sel, 6);
    tick();
    chk("bp_next_rsp", rsp_data, 8'h1E);
    chk("bp_next_valid", rsp_valid, 1);
    tick();

    // reset during cycle 2 of an 8-step rotate left
    cmd_valid = 1'b1; cmd_op = 3'd7; cmd_data = 8'h00; cmd_cnt = 3'd7;
    tick();
    cmd_valid = 1'b0;
    chk("mr_sel_c1", sel, 7);
    tick();
    clr = 1'b1;
    #1;
    chk("mr_sel_clr", sel, 0);
    chk("mr_ready", cmd_ready, 0);
    chk("mr_busy", busy, 0);
    chk("mr_decide", reg_decide, 0);
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_rsp_data", rsp_data, 0);
    tick();
    clr = 1'b0;
    #1;
    chk("mr_reg_zero", reg_q, 8'h00);
    chk("mr_ready_after", cmd_ready, 1);
    chk("mr_busy_after", busy, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid) seen++;
      tick();
    end
    chk("mr_no_rsp", seen, 0);
    chk("mr_reg_still_zero", reg_q, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
